// File: rtl/iecdrv_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block interface between up to four
// drive track loaders. The winner's command is latched and forwarded to the
// host; the host ack is routed back to the granted loader only.
module iecdrv_sd_arbiter #(
   parameter int NDRIVES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [32*NDRIVES-1:0]   req_lba,
   input  logic [6*NDRIVES-1:0]    req_blk_cnt,
   input  logic [NDRIVES-1:0]      req_rd,
   input  logic [NDRIVES-1:0]      req_wr,
   output logic [NDRIVES-1:0]      req_ack,
   output logic [31:0]             sd_lba,
   output logic [5:0]              sd_blk_cnt,
   output logic                    sd_rd,
   output logic                    sd_wr,
   input  logic                    sd_ack,
   output logic [1:0]              sd_drive,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

   localparam logic [1:0] LAST = 2'(NDRIVES - 1);
   localparam logic [2:0] ND3  = 3'(NDRIVES);

   state_t      state_reg, state_next;
   logic [1:0]  ptr_reg, ptr_next;
   logic [1:0]  drive_reg, drive_next;
   logic [31:0] lba_reg, lba_next;
   logic [5:0]  cnt_reg, cnt_next;
   logic        rd_reg, rd_next;
   logic        wr_reg, wr_next;
   // Set by reset; keeps a host ack left over from an aborted transfer from
   // being taken for the ack of a new command. Clears once the ack is low.
   logic        stale_ack_reg;

   // Requester inputs widened to four fixed slots; unused slots read idle.
   logic [31:0] lba_arr [4];
   logic [5:0]  cnt_arr [4];
   logic [3:0]  rd4, wr4, pend;

   logic        found;
   logic [1:0]  win;
   logic [2:0]  idx;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         if (gi < NDRIVES) begin : g_used
            assign lba_arr[gi] = req_lba[32*gi +: 32];
            assign cnt_arr[gi] = req_blk_cnt[6*gi +: 6];
            assign rd4[gi]     = req_rd[gi];
            assign wr4[gi]     = req_wr[gi];
         end else begin : g_unused
            assign lba_arr[gi] = '0;
            assign cnt_arr[gi] = '0;
            assign rd4[gi]     = 1'b0;
            assign wr4[gi]     = 1'b0;
         end
      end
   endgenerate

   assign pend = rd4 | wr4;

   // Round-robin search starting at ptr; scanning from the far end down lets
   // the nearest pending requester overwrite any later one.
   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      idx   = 3'd0;
      for (int k = NDRIVES - 1; k >= 0; k--) begin
         idx = {1'b0, ptr_reg} + 3'(k);
         if (idx >= ND3) begin
            idx = idx - ND3;
         end
         if (pend[idx[1:0]]) begin
            found = 1'b1;
            win   = idx[1:0];
         end
      end
   end

   // Next-state and command register logic.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      drive_next = drive_reg;
      lba_next   = lba_reg;
      cnt_next   = cnt_reg;
      rd_next    = rd_reg;
      wr_next    = wr_reg;
      case (state_reg)
         IDLE: begin
            if (found && !(stale_ack_reg && sd_ack)) begin
               drive_next = win;
               lba_next   = lba_arr[win];
               cnt_next   = cnt_arr[win];
               // Write has priority when a loader raises both.
               wr_next    = wr4[win];
               rd_next    = ~wr4[win];
               ptr_next   = (win == LAST) ? 2'd0 : win + 2'd1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (sd_ack) begin
               rd_next    = 1'b0;
               wr_next    = 1'b0;
               state_next = XFER;
            end else if (!pend[drive_reg]) begin
               rd_next    = 1'b0;
               wr_next    = 1'b0;
               state_next = IDLE;
            end
         end
         XFER: begin
            if (!sd_ack) begin
               state_next = GAP;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and latched-command registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         ptr_reg       <= 2'd0;
         drive_reg     <= 2'd0;
         lba_reg       <= 32'd0;
         cnt_reg       <= 6'd0;
         rd_reg        <= 1'b0;
         wr_reg        <= 1'b0;
         stale_ack_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         drive_reg     <= drive_next;
         lba_reg       <= lba_next;
         cnt_reg       <= cnt_next;
         rd_reg        <= rd_next;
         wr_reg        <= wr_next;
         stale_ack_reg <= stale_ack_reg & sd_ack;
      end
   end

   // Host ack reaches only the granted loader, and only while it owns the bus.
   generate
      for (gi = 0; gi < NDRIVES; gi++) begin : g_ack
         assign req_ack[gi] = sd_ack && (drive_reg == 2'(gi)) &&
                              ((state_reg == REQ) || (state_reg == XFER));
      end
   endgenerate

   assign sd_lba     = lba_reg;
   assign sd_blk_cnt = cnt_reg;
   assign sd_rd      = rd_reg;
   assign sd_wr      = wr_reg;
   assign sd_drive   = drive_reg;
   assign busy       = (state_reg != IDLE);

endmodule
